fetch_decode: RTL

Front-end stage of the 16-bit CPU. It fetches one instruction per pass over a req/ack instruction-memory port, decodes it into the ALU's control fields (alu_op, data_imm, data_d_we) and register selects, then sequences the ALU enable and write-back/PC-advance strobes. It sits directly upstream of the ALU and drives that block's en, alu_op, data_imm and data_d_we inputs.

---
 rtl/fetch_decode_pkg.sv | 61 ++++++
 rtl/fetch_decode_if.sv | 12 +
 rtl/fetch_decode_decode.sv | 27 ++
 rtl/fetch_decode.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared constants and types for the CPU front end: opcodes, instruction field
// positions, fetch/decode FSM states and the decoded-instruction bundle.
package fetch_decode_pkg;

  localparam int INSTR_W = 16;
  localparam int SEL_W   = 3;
  localparam int IMM_W   = 8;

  // Instruction field positions (LSB of each field)
  localparam int OPC_LSB  = 12;
  localparam int RD_LSB   = 9;
  localparam int FLAG_BIT = 8;
  localparam int RA_LSB   = 5;
  localparam int RB_LSB   = 2;
  localparam int IMM_LSB  = 0;

  localparam logic [3:0] OPCODE_ADD    = 4'd0;
  localparam logic [3:0] OPCODE_SUB    = 4'd1;
  localparam logic [3:0] OPCODE_OR     = 4'd2;
  localparam logic [3:0] OPCODE_XOR    = 4'd3;
  localparam logic [3:0] OPCODE_AND    = 4'd4;
  localparam logic [3:0] OPCODE_NOT    = 4'd5;
  localparam logic [3:0] OPCODE_READ   = 4'd6;
  localparam logic [3:0] OPCODE_WRITE  = 4'd7;
  localparam logic [3:0] OPCODE_LOAD   = 4'd8;
  localparam logic [3:0] OPCODE_CMP    = 4'd9;
  localparam logic [3:0] OPCODE_SHL    = 4'd10;
  localparam logic [3:0] OPCODE_SHR    = 4'd11;
  localparam logic [3:0] OPCODE_JUMP   = 4'd12;
  localparam logic [3:0] OPCODE_JUMPEQ = 4'd13;
  localparam logic [3:0] OPCODE_NOP    = 4'd14;
  localparam logic [3:0] OPCODE_RSVD   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT
  } state_t;

  typedef struct packed {
    logic [4:0]         alu_op;
    logic [INSTR_W-1:0] data_imm;
    logic               data_d_we;
    logic [SEL_W-1:0]   sel_d;
    logic [SEL_W-1:0]   sel_a;
    logic [SEL_W-1:0]   sel_b;
    logic               is_illegal;
  } dec_t;

  // Stores, jumps, the NOP slot and the reserved opcode leave rD untouched.
  function automatic logic writes_rd(input logic [3:0] opc);
    case (opc)
      OPCODE_ADD, OPCODE_SUB, OPCODE_OR, OPCODE_XOR, OPCODE_AND, OPCODE_NOT,
      OPCODE_READ, OPCODE_LOAD, OPCODE_CMP, OPCODE_SHL, OPCODE_SHR:
        writes_rd = 1'b1;
      OPCODE_WRITE, OPCODE_JUMP, OPCODE_JUMPEQ, OPCODE_NOP, OPCODE_RSVD:
        writes_rd = 1'b0;
      default:
        writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction-memory req/ack port between the fetch stage (master) and memory.
interface fetch_decode_if;
  import fetch_decode_pkg::*;

  logic               req;
  logic [INSTR_W-1:0] addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/fetch_decode_decode.sv
// Combinational instruction decoder: one 16-bit word into ALU control fields,
// register selects and an illegal-opcode flag.
module instr_decode
  import fetch_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  logic [3:0]       opc;
  logic [IMM_W-1:0] imm;

  assign opc = instr[OPC_LSB +: 4];
  assign imm = instr[IMM_LSB +: IMM_W];

  always_comb begin
    dec            = '0;
    dec.alu_op     = {opc, instr[FLAG_BIT]};
    dec.data_imm   = {imm, imm};
    dec.data_d_we  = writes_rd(opc);
    dec.sel_d      = instr[RD_LSB +: SEL_W];
    dec.sel_a      = instr[RA_LSB +: SEL_W];
    dec.sel_b      = instr[RB_LSB +: SEL_W];
    dec.is_illegal = (opc == OPCODE_RSVD);
  end

endmodule

// File: rtl/fetch_decode.sv
// CPU front end: fetch over req/ack, decode, then sequence ALU enable and
// write-back / PC-advance strobes. Sticky illegal and bus_error park in HALT.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic [INSTR_W-1:0] pc,
  fetch_decode_if.master     imem,
  output logic               alu_en,
  output logic [4:0]         alu_op,
  output logic [INSTR_W-1:0] data_imm,
  output logic               data_d_we,
  output logic [SEL_W-1:0]   sel_d,
  output logic [SEL_W-1:0]   sel_a,
  output logic [SEL_W-1:0]   sel_b,
  output logic               wb_en,
  output logic               pc_advance,
  output logic               illegal,
  output logic               bus_error
);

  localparam int             CNT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam bit             TO_EN    = (FETCH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] addr_q;
  logic [CNT_W-1:0]   cnt;
  logic               req_q;
  logic               ack_pend;
  logic               fetch_first;
  dec_t               dec;

  instr_decode u_dec (.instr(ir), .dec(dec));

  // pc moves on the very edge that leaves WB, so the fetch address follows pc
  // through the first FETCH cycle and is held from the next edge on.
  assign imem.addr = fetch_first ? pc : addr_q;
  assign imem.req  = req_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      addr_q      <= '0;
      cnt         <= '0;
      req_q       <= 1'b0;
      ack_pend    <= 1'b0;
      fetch_first <= 1'b0;
      alu_en      <= 1'b0;
      alu_op      <= '0;
      data_imm    <= '0;
      data_d_we   <= 1'b0;
      sel_d       <= '0;
      sel_a       <= '0;
      sel_b       <= '0;
      wb_en       <= 1'b0;
      pc_advance  <= 1'b0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
    end else if (stall) begin
      // Everything freezes, but a memory ack is one-shot and must not be lost.
      if (state == ST_FETCH && imem.ack && !ack_pend) begin
        ir       <= imem.data;
        ack_pend <= 1'b1;
      end
    end else begin
      alu_en     <= 1'b0;
      wb_en      <= 1'b0;
      pc_advance <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state       <= ST_FETCH;
            req_q       <= 1'b1;
            fetch_first <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fetch_first) begin
            addr_q      <= pc;
            fetch_first <= 1'b0;
          end
          if (imem.ack || ack_pend) begin
            if (!ack_pend) ir <= imem.data;
            ack_pend <= 1'b0;
            req_q    <= 1'b0;
            cnt      <= '0;
            state    <= ST_DECODE;
          end else if (TO_EN && cnt == CNT_LAST) begin
            bus_error <= 1'b1;
            req_q     <= 1'b0;
            cnt       <= '0;
            state     <= ST_HALT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          alu_op    <= dec.alu_op;
          data_imm  <= dec.data_imm;
          data_d_we <= dec.data_d_we;
          sel_d     <= dec.sel_d;
          sel_a     <= dec.sel_a;
          sel_b     <= dec.sel_b;
          if (dec.is_illegal) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else begin
            alu_en  <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wb_en      <= 1'b1;
          pc_advance <= 1'b1;
          state      <= ST_WB;
        end
        ST_WB: begin
          if (run) begin
            state       <= ST_FETCH;
            req_q       <= 1'b1;
            fetch_first <= 1'b1;
          end else begin
            state       <= ST_IDLE;
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
